// File: rtl/hier_leaf_pkg.sv
// hier_leaf_pkg
//   Shared types and default sizes for the leaf skid stages that sit below
//   the fan-out hierarchy nodes.
//   - skid_state_t : occupancy state of a leaf (EMPTY / ONE / FULL)
//   - LEAF_WIDTH   : default payload width used by parents when instantiating
//   - LEAF_CNT_W   : default transfer counter width used by parents
package hier_leaf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int LEAF_WIDTH = 8;
  localparam int LEAF_CNT_W = 16;

endpackage

// File: rtl/hier_leaf_skid_stage.sv
// hier_leaf_skid_stage
//   Two-entry skid buffer with registered handshakes on both sides and a
//   wrapping count of completed output transfers.
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   in_valid   - upstream offers in_data
//   in_ready   - stage can take a word this cycle (registered)
//   in_data    - upstream payload
//   out_valid  - out_data holds a valid word (registered)
//   out_ready  - downstream takes the word this cycle
//   out_data   - downstream payload (registered, from the main register)
//   xfer_count - completed output transfers, modulo 2^CNT_W
//   busy       - at least one word is held
module hier_leaf_skid_stage
  import hier_leaf_pkg::*;
#(
  parameter int WIDTH = LEAF_WIDTH,
  parameter int CNT_W = LEAF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_count,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  skid_state_t      r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [CNT_W-1:0] r_count;

  logic w_accept;
  logic w_emit;
  logic w_main_from_in;
  logic w_main_from_skid;
  logic w_skid_load;

  // Handshakes only look at the registered ready/valid flags, so neither
  // output depends combinationally on in_valid or out_ready.
  assign w_accept = in_valid & r_in_ready;
  assign w_emit   = r_out_valid & out_ready;

  // Data-path load enables, decoded from the current state and handshakes.
  always_comb begin
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    case (r_state)
      EMPTY: w_main_from_in = w_accept;
      ONE: begin
        // Accept while emitting replaces main; accept while stalled spills to skid.
        w_main_from_in = w_accept & w_emit;
        w_skid_load    = w_accept & ~w_emit;
      end
      FULL:    w_main_from_skid = w_emit;
      default: ;
    endcase
  end

  // Control FSM with registered handshake outputs and the transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_emit) begin
        r_count <= r_count + CNT_ONE;
      end
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_state     <= ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        ONE: begin
          if (w_accept && !w_emit) begin
            r_state     <= FULL;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
          end else if (!w_accept && w_emit) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        FULL: begin
          // in_ready is low here, so only an emit can change occupancy.
          if (w_emit) begin
            r_state     <= ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Payload registers carry no reset; their contents only matter while the
  // state marks them as occupied.
  always_ff @(posedge clk) begin
    if (w_main_from_in) begin
      r_main <= in_data;
    end else if (w_main_from_skid) begin
      r_main <= r_skid;
    end
    if (w_skid_load) begin
      r_skid <= in_data;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_main;
  assign xfer_count = r_count;
  assign busy       = (r_state != EMPTY);

endmodule

// File: tb/tb_hier_leaf_skid_stage.sv
// tb_hier_leaf_skid_stage
//   Scoreboard bench: every accepted word is queued as the expected output,
//   and a monitor pops and compares on every emit. A second instance with a
//   2-bit counter exercises the counter wrap.
module tb_hier_leaf_skid_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [15:0] xfer_count;
  logic       busy;

  logic       in_valid2;
  logic       in_ready2;
  logic [7:0] in_data2;
  logic       out_valid2;
  logic       out_ready2;
  logic [7:0] out_data2;
  logic [1:0] xfer_count2;
  logic       busy2;

  int n_checks;
  int n_fail;
  logic [7:0] exp_q[$];
  int exp_cnt;

  hier_leaf_skid_stage #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_count(xfer_count), .busy(busy)
  );

  hier_leaf_skid_stage #(.WIDTH(8), .CNT_W(2)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .xfer_count(xfer_count2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: an emit happens at the coming edge when out_valid & out_ready
  // are seen here with rst low.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_emit: got %0h expected no word", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL emit_data: got %0h expected %0h", out_data, e);
        end else begin
          $display("emit data=%02h", out_data);
        end
      end
      exp_cnt++;
    end
  end

  // Offer one word; returns after the edge that accepted it. stalls counts
  // cycles spent waiting for in_ready.
  task automatic send(input logic [7:0] d, output int stalls);
    bit done;
    done = 0;
    stalls = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        exp_q.push_back(d);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      if (!done && stalls > 50) begin
        check("send_timeout", 32'(stalls), 32'd0);
        done = 1;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    exp_q.delete();
    exp_cnt = 0;
  endtask

  initial begin
    int st;
    logic [1:0] wrap_exp [5];
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    rst = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    in_valid2 = 1'b0; in_data2 = 8'h00; out_ready2 = 1'b0;
    @(posedge clk);
    #1;

    // Reset with in_valid high for two cycles.
    in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    do_reset(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(xfer_count), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst_no_word", 32'(out_valid), 32'd0);

    // Streaming 0x01..0x10 with out_ready high.
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send(8'(i), st);
      check("stream_no_stall", 32'(st), 32'd0);
      check("stream_latency", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'(i)});
    end
    in_valid = 1'b0;
    drain();
    check("stream_count", 32'(xfer_count), 32'd16);

    // Backpressure: A1, A2 fill the stage, A3 waits.
    out_ready = 1'b0;
    send(8'hA1, st);
    check("bp_in_ready_one", 32'(in_ready), 32'd1);
    send(8'hA2, st);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 8'hA3;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    check("bp_hold_data", 32'(out_data), 32'h A1);
    check("bp_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    send(8'hA3, st);
    check("bp_a3_waited", 32'(st), 32'd1);
    in_valid = 1'b0;
    drain();
    check("bp_count", 32'(xfer_count), 32'd19);

    // Simultaneous accept and emit in ONE.
    out_ready = 1'b0;
    send(8'h33, st);
    out_ready = 1'b1;
    send(8'h55, st);
    in_valid = 1'b0; out_ready = 1'b0;
    check("sim_out_data", 32'(out_data), 32'h55);
    check("sim_state_one", {30'd0, out_valid, in_ready}, 32'd3);
    check("sim_count", 32'(xfer_count), 32'd20);
    drain();
    check("sim_count_drain", 32'(xfer_count), 32'd21);

    // Counter wrap on the 2-bit instance.
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    out_ready2 = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      in_valid2 = (i < 5);
      in_data2  = 8'(8'hC0 + i);
      @(posedge clk);
      #1;
      if (i > 0) begin
        check($sformatf("wrap_count_%0d", i), 32'(xfer_count2), 32'(wrap_exp[i-1]));
      end
    end
    in_valid2 = 1'b0;

    // Reset while FULL with out_ready high: held words must vanish.
    out_ready = 1'b0;
    send(8'h11, st);
    send(8'h22, st);
    check("mid_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    do_reset(1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(xfer_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("mid_rst_no_word", 32'(out_valid), 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
